dmem_responder: RTL and testbench

Responder end of the CPU data-memory port: accepts the MEM-stage request (enable, byte write-enables, address, write data), serves it from an on-chip word array after a programmable latency, and returns read data plus a stall to hold the pipeline. It sits between the CPU core's MEM-stage request signals and the pipeline hazard unit, which consumes `stall`.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_bank.sv | 39 +++
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder:
// FSM state encoding and latency counter width.
package dmem_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data port between the CPU (master) and the
// memory responder (slave).
interface dmem_responder_if;

    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    modport master (
        output en, wen, addr, wdata,
        input  rdata, stall, err
    );

    modport slave (
        input  en, wen, addr, wdata,
        output rdata, stall, err
    );

endinterface

// File: rtl/dmem_bank.sv
// Single-port word array with per-byte write enables and a
// registered, read-before-write data output.
module dmem_bank #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [3:0]        we_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Array contents survive reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: latches a request, waits LATENCY cycles,
// then accesses dmem_bank. Optional range check: DMEM_RESP_RANGE_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    import dmem_pkg::*;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              hi_q, hi_d;
    logic [3:0]        wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              access;
    logic              hi_addr;
    logic              unused_addr;
    logic [31:0]       bank_rdata;

    // hi_addr flags bits above the array; without the check they alias.
`ifdef DMEM_RESP_RANGE_CHECK_EN
    assign hi_addr     = |bus.addr[31:ADDR_W+2];
    assign unused_addr = ^bus.addr[1:0];
`else
    assign hi_addr     = 1'b0;
    assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = bus.addr[ADDR_W+1:2];
                    hi_d    = hi_addr;
                    wen_d   = bus.wen;
                    wdata_d = bus.wdata;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access  = 1'b1;
                    err_d   = hi_q;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hi_q    <= 1'b0;
            wen_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    dmem_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .en_i    (access),
        .idx_i   (idx_q),
        .we_i    (hi_q ? 4'h0 : wen_q),
        .wdata_i (wdata_q),
        .rdata_o (bank_rdata)
    );

    // A suppressed access reports zero data even though the bank held it.
    assign bus.rdata = err_q ? 32'h0 : bank_rdata;
    assign bus.err   = err_q;
    assign bus.stall = (state_q == S_IDLE) ? bus.en
                                           : (state_q == S_BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 1 and 15.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if b2 ();
    dmem_responder_if b1 ();
    dmem_responder_if b15 ();

    dmem_responder #(.ADDR_W(10), .LATENCY(2))
        u2 (.clk(clk), .rst(rst), .bus(b2));
    dmem_responder #(.ADDR_W(10), .LATENCY(1))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_responder #(.ADDR_W(10), .LATENCY(15))
        u15 (.clk(clk), .rst(rst), .bus(b15));

`ifdef DMEM_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request on b2, count stall cycles, sample DONE outputs.
    task automatic do_req(input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] d, output int sw,
                          output logic [31:0] rd, output logic e);
        @(negedge clk);
        b2.en = 1'b1; b2.addr = a; b2.wen = w; b2.wdata = d;
        #1;
        sw = 0;
        while (b2.stall && sw < 40) begin
            sw++;
            @(negedge clk);
        end
        rd = b2.rdata;
        e  = b2.err;
        b2.en = 1'b0;
    endtask

    int          sw, n1, n15, ndone, d0, d1;
    logic [31:0] rd;
    logic        e;
    logic [7:0]  pat;
    logic [31:0] rd0, rd1;

    initial begin
        rst = 1'b1;
        b2.en = 0;  b2.wen = 0;  b2.addr = 0;  b2.wdata = 0;
        b1.en = 0;  b1.wen = 0;  b1.addr = 0;  b1.wdata = 0;
        b15.en = 0; b15.wen = 0; b15.addr = 0; b15.wdata = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(b2.stall), 32'd0);
        chk("rst_rdata", b2.rdata, 32'h0);
        chk("rst_err", 32'(b2.err), 32'd0);

        do_req(32'h100, 4'hF, 32'hDEADBEEF, sw, rd, e);
        chk("wr_stall", 32'(sw), 32'd3);
        do_req(32'h100, 4'h0, 32'h0, sw, rd, e);
        chk("rd_stall", 32'(sw), 32'd3);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", 32'(e), 32'd0);
        @(negedge clk);
        chk("hold_rdata", b2.rdata, 32'hDEADBEEF);
        chk("idle_stall", 32'(b2.stall), 32'd0);

        do_req(32'h100, 4'b0010, 32'h0000AA00, sw, rd, e);
        chk("rbw_data", rd, 32'hDEADBEEF);
        do_req(32'h100, 4'h0, 32'h0, sw, rd, e);
        chk("partial", rd, 32'hDEADAAEF);

        // en held high through DONE: DONE never starts a request.
        do_req(32'h104, 4'hF, 32'h01020304, sw, rd, e);
        @(negedge clk);
        b2.en = 1'b1; b2.addr = 32'h104; b2.wen = 4'h0;
        #1;
        ndone = 0; d0 = 0; d1 = 0; rd0 = 0; rd1 = 0;
        for (int i = 0; i < 8; i++) begin
            pat[i] = b2.stall;
            if (!b2.stall) begin
                if (ndone == 0) begin d0 = i; rd0 = b2.rdata; end
                else begin d1 = i; rd1 = b2.rdata; end
                ndone++;
            end
            if (i < 7) @(negedge clk);
        end
        b2.en = 1'b0;
        chk("b2b_pattern", 32'(pat), 32'h77);
        chk("b2b_count", 32'(ndone), 32'd2);
        chk("b2b_spacing", 32'(d1 - d0), 32'd4);
        chk("b2b_rd0", rd0, 32'h01020304);
        chk("b2b_rd1", rd1, 32'h01020304);

        // Reset in the middle of BUSY discards the pending write.
        do_req(32'h200, 4'hF, 32'h0BADF00D, sw, rd, e);
        do_req(32'h200, 4'h0, 32'h0, sw, rd, e);
        chk("pre_rst_rd", rd, 32'h0BADF00D);
        @(negedge clk);
        b2.en = 1'b1; b2.addr = 32'h200; b2.wen = 4'hF;
        b2.wdata = 32'h12345678;
        @(negedge clk);
        b2.en = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_stall", 32'(b2.stall), 32'd0);
        chk("midrst_rdata", b2.rdata, 32'h0);
        chk("midrst_err", 32'(b2.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_req(32'h200, 4'h0, 32'h0, sw, rd, e);
        chk("post_rst_rd", rd, 32'h0BADF00D);

        // Out-of-range address: error when checked, alias otherwise.
        do_req(32'h0, 4'hF, 32'h11223344, sw, rd, e);
        do_req(32'h80000000, 4'h0, 32'h0, sw, rd, e);
        chk("oob_rd_err", 32'(e), RC ? 32'd1 : 32'd0);
        chk("oob_rd_data", rd, RC ? 32'h0 : 32'h11223344);
        do_req(32'h80000000, 4'hF, 32'hCAFEF00D, sw, rd, e);
        chk("oob_wr_err", 32'(e), RC ? 32'd1 : 32'd0);
        do_req(32'h0, 4'h0, 32'h0, sw, rd, e);
        chk("word0_after", rd, RC ? 32'h11223344 : 32'hCAFEF00D);
        chk("word0_err", 32'(e), 32'd0);

        // Latency extremes on the other two instances.
        @(negedge clk);
        b1.en = 1'b1;  b1.addr = 32'h8;  b1.wen = 4'h0;
        b15.en = 1'b1; b15.addr = 32'h8; b15.wen = 4'h0;
        #1;
        n1 = 0; n15 = 0;
        for (int i = 0; i < 20; i++) begin
            if (b1.stall) n1++; else b1.en = 1'b0;
            if (b15.stall) n15++; else b15.en = 1'b0;
            @(negedge clk);
        end
        chk("lat1_stall", 32'(n1), 32'd2);
        chk("lat15_stall", 32'(n15), 32'd16);
        chk("lat15_err", 32'(b15.err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
